// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the MEM stage.
//   mem_op_e   - 4-bit memory operation codes carried on the EX/MEM mem_op field
//   state_e    - MEM stage access FSM states
//   helpers    - op classification, misalignment test, byte-enable and
//                store-lane formatting used by the top and by future cache logic
package mem_access_pkg;

    localparam int MEM_OP_W = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Unlisted codes fall out of both predicates and behave as OP_NONE.
    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op,
                                           input logic [1:0] a);
        logic r;
        r = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = a[0];
            OP_LW, OP_SW:         r = |a;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [MEM_OP_W-1:0] op,
                                                input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: be = a[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store value across all lanes so the memory only needs
    // the byte enables to pick the right bytes.
    function automatic logic [31:0] store_data(input logic [MEM_OP_W-1:0] op,
                                               input logic [31:0] sdata);
        logic [31:0] d;
        d = sdata;
        case (op)
            OP_SB:   d = {4{sdata[7:0]}};
            OP_SH:   d = {2{sdata[15:0]}};
            default: d = sdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: combinational load-data alignment.
//   op    - load op code (mem_op_e)
//   a     - low two byte-address bits selecting the lane
//   rdata - raw 32-bit word returned by memory
//   value - selected byte/half/word, sign- or zero-extended to 32 bits
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [MEM_OP_W-1:0] op,
    input  logic [1:0]          a,
    input  logic [31:0]         rdata,
    output logic [31:0]         value
);

    logic [7:0] lanes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = lanes[a];
    assign half_sel = a[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (op)
            OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  value = {24'd0, byte_sel};
            OP_LH:   value = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage of the 5-stage RISC-V core, including the MEM/WB register.
//   clk, rst         - clock; asynchronous active-low reset
//   mem_wd/mem_wreg  - destination register and write enable from EX/MEM
//   mem_data         - ALU result, also the effective byte address for memory ops
//   mem_op/mem_sdata - memory op code and store data
//   stall_req        - holds EX/MEM and earlier stages (combinational)
//   misalign         - one-cycle registered pulse for a misaligned access
//   dmem_*           - single-outstanding req/ready data-memory port
//   wb_wd/wb_wreg/wb_data - registered write-back result
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          mem_wd,
    input  logic                mem_wreg,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic [MEM_OP_W-1:0] mem_op,
    input  logic [DATA_W-1:0]   mem_sdata,
    output logic                stall_req,
    output logic                misalign,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [3:0]          dmem_be,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_ready,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic [4:0]          wb_wd,
    output logic                wb_wreg,
    output logic [DATA_W-1:0]   wb_data
);

    state_e              state_reg;
    logic [MEM_OP_W-1:0] lat_op_reg;
    logic [ADDR_W-1:0]   lat_addr_reg;
    logic [DATA_W-1:0]   lat_sdata_reg;
    logic [4:0]          lat_wd_reg;
    logic                lat_wreg_reg;

    logic                is_mem;
    logic                bad_align;
    logic                issue;
    logic                in_req;
    logic [MEM_OP_W-1:0] sel_op;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_sdata;
    logic [31:0]         load_value;

    assign is_mem    = is_load(mem_op) | is_store(mem_op);
    assign bad_align = is_mem & is_misaligned(mem_op, mem_data[1:0]);
    // The request goes out in the same cycle the op arrives; gating with rst
    // keeps the combinational outputs quiet while reset is held.
    assign issue     = rst & (state_reg == ST_IDLE) & is_mem & ~bad_align;
    assign in_req    = (state_reg == ST_REQ);

    // In REQ the port is driven from the latched copy so it stays stable
    // even though EX/MEM contents are only guaranteed held by the stall.
    assign sel_op    = in_req ? lat_op_reg    : mem_op;
    assign sel_addr  = in_req ? lat_addr_reg  : mem_data[ADDR_W-1:0];
    assign sel_sdata = in_req ? lat_sdata_reg : mem_sdata;

    assign dmem_req   = issue | in_req;
    assign stall_req  = issue | (in_req & ~dmem_ready);
    assign dmem_we    = is_store(sel_op);
    assign dmem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
    assign dmem_be    = byte_enables(sel_op, sel_addr[1:0]);
    assign dmem_wdata = store_data(sel_op, sel_sdata);

    mem_access_load_align u_load_align (
        .op    (lat_op_reg),
        .a     (lat_addr_reg[1:0]),
        .rdata (dmem_rdata),
        .value (load_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            lat_op_reg    <= '0;
            lat_addr_reg  <= '0;
            lat_sdata_reg <= '0;
            lat_wd_reg    <= '0;
            lat_wreg_reg  <= 1'b0;
            misalign      <= 1'b0;
            wb_wd         <= '0;
            wb_wreg       <= 1'b0;
            wb_data       <= '0;
        end else begin
            misalign <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bad_align) begin
                        misalign <= 1'b1;
                        wb_wreg  <= 1'b0;
                    end else if (is_mem) begin
                        state_reg     <= ST_REQ;
                        lat_op_reg    <= mem_op;
                        lat_addr_reg  <= mem_data[ADDR_W-1:0];
                        lat_sdata_reg <= mem_sdata;
                        lat_wd_reg    <= mem_wd;
                        lat_wreg_reg  <= mem_wreg;
                        wb_wreg       <= 1'b0;
                    end else begin
                        wb_wd   <= mem_wd;
                        wb_wreg <= mem_wreg;
                        wb_data <= mem_data;
                    end
                end
                ST_REQ: begin
                    // Bubble every stalled cycle; only completion may write back.
                    wb_wreg <= 1'b0;
                    if (dmem_ready) begin
                        state_reg <= ST_IDLE;
                        if (is_load(lat_op_reg)) begin
                            wb_data <= load_value;
                            wb_wd   <= lat_wd_reg;
                            wb_wreg <= lat_wreg_reg;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
